decode_stage: RTL

- Registered RV32 instruction-decode pipeline stage between fetch (IF) and execute (EX).
- Decodes each fetched instruction into a packed control bundle and buffers it in a 2-entry skid buffer with valid/ready on both sides.
- Successor to the purely combinational decoder. Adds: parametrised XLEN, optional M-extension decode, full illegal-instruction detection, flush, back-pressure, and a saturating illegal-instruction counter.

---
 rtl/decode_pkg.sv | 128 ++++++++++++
 rtl/decode_logic.sv | 178 +++++++++++++++++
 rtl/decode_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV32 decode stage.
// Holds the decoded control bundle, one-hot op indices and RV32I/M field values.
package decode_pkg;

    localparam int unsigned ILEN           = 32;
    localparam int unsigned XLEN_SUPPORTED = 32;
    localparam int unsigned REG_W          = 5;

    localparam int unsigned ALU_OP_ADD    = 0;
    localparam int unsigned ALU_OP_SUB    = 1;
    localparam int unsigned ALU_OP_SLL    = 2;
    localparam int unsigned ALU_OP_SLT    = 3;
    localparam int unsigned ALU_OP_SLTU   = 4;
    localparam int unsigned ALU_OP_XOR    = 5;
    localparam int unsigned ALU_OP_SRL    = 6;
    localparam int unsigned ALU_OP_SRA    = 7;
    localparam int unsigned ALU_OP_OR     = 8;
    localparam int unsigned ALU_OP_AND    = 9;
    localparam int unsigned ALU_OP_MUL    = 10;
    localparam int unsigned ALU_OP_MULH   = 11;
    localparam int unsigned ALU_OP_MULHSU = 12;
    localparam int unsigned ALU_OP_MULHU  = 13;
    localparam int unsigned ALU_OP_DIV    = 14;
    localparam int unsigned ALU_OP_DIVU   = 15;
    localparam int unsigned ALU_OP_REM    = 16;
    localparam int unsigned ALU_OP_REMU   = 17;
    localparam int unsigned ALU_OP_W      = 18;

    localparam int unsigned BRANCH_OP_EQ  = 0;
    localparam int unsigned BRANCH_OP_NE  = 1;
    localparam int unsigned BRANCH_OP_LT  = 2;
    localparam int unsigned BRANCH_OP_GE  = 3;
    localparam int unsigned BRANCH_OP_LTU = 4;
    localparam int unsigned BRANCH_OP_GEU = 5;
    localparam int unsigned BRANCH_OP_W   = 6;

    localparam int unsigned MEM_OP_B = 0;
    localparam int unsigned MEM_OP_H = 1;
    localparam int unsigned MEM_OP_W = 2;
    localparam int unsigned MEM_OP_WIDTH = 3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB   = 3'd0;
    localparam logic [2:0] F3_LH   = 3'd1;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;
    localparam logic [2:0] F3_SW   = 3'd2;
    localparam logic [2:0] F3_JALR = 3'd0;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef struct packed {
        logic [ALU_OP_W-1:0]     alu_op;
        logic [BRANCH_OP_W-1:0]  branch_op;
        logic [MEM_OP_WIDTH-1:0] mem_op;
        logic                    src1_sel_pc;
        logic                    src1_sel_zero;
        logic                    src2_sel_imm;
        logic [REG_W-1:0]        rd;
        logic [REG_W-1:0]        rs1;
        logic [REG_W-1:0]        rs2;
        logic                    rd_write;
        logic                    rs1_read;
        logic                    rs2_read;
        logic                    mem_read;
        logic                    mem_write;
        logic [ILEN-1:0]         imm;
        logic                    unsign;
        logic                    jump;
        logic                    branch;
        logic                    is_muldiv;
        logic                    illegal;
    } decode_ctrl_t;

    localparam int unsigned CTRL_W = $bits(decode_ctrl_t);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Base integer ALU op from funct3; alt selects SUB/SRA.
    function automatic logic [ALU_OP_W-1:0] alu_base(input logic [2:0] f3, input logic alt);
        logic [ALU_OP_W-1:0] op;
        op = '0;
        case (f3)
            F3_ADD:  op[alt ? ALU_OP_SUB : ALU_OP_ADD] = 1'b1;
            F3_SLL:  op[ALU_OP_SLL]  = 1'b1;
            F3_SLT:  op[ALU_OP_SLT]  = 1'b1;
            F3_SLTU: op[ALU_OP_SLTU] = 1'b1;
            F3_XOR:  op[ALU_OP_XOR]  = 1'b1;
            F3_SR:   op[alt ? ALU_OP_SRA : ALU_OP_SRL] = 1'b1;
            F3_OR:   op[ALU_OP_OR]   = 1'b1;
            default: op[ALU_OP_AND]  = 1'b1;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I(+M) instruction decoder producing a decode_ctrl_t bundle.
// Illegal encodings clear every side-effect enable and raise illegal.
module decode_logic
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [ILEN-1:0]   instr,
    output logic [CTRL_W-1:0] ctrl_c
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [ILEN-1:0] imm_i;
    logic [ILEN-1:0] imm_s;
    logic [ILEN-1:0] imm_b;
    logic [ILEN-1:0] imm_u;
    logic [ILEN-1:0] imm_j;
    logic            legal;
    decode_ctrl_t    ctrl;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        ctrl     = '0;
        legal    = 1'b0;
        ctrl.rd  = instr[11:7];
        ctrl.rs1 = instr[19:15];
        ctrl.rs2 = instr[24:20];

        if (instr[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI: begin
                    legal              = 1'b1;
                    ctrl.rd_write      = 1'b1;
                    ctrl.src1_sel_zero = 1'b1;
                    ctrl.src2_sel_imm  = 1'b1;
                    ctrl.alu_op        = alu_base(F3_ADD, 1'b0);
                    ctrl.imm           = imm_u;
                end
                OPC_AUIPC: begin
                    legal             = 1'b1;
                    ctrl.rd_write     = 1'b1;
                    ctrl.src1_sel_pc  = 1'b1;
                    ctrl.src2_sel_imm = 1'b1;
                    ctrl.alu_op       = alu_base(F3_ADD, 1'b0);
                    ctrl.imm          = imm_u;
                end
                OPC_JAL: begin
                    legal             = 1'b1;
                    ctrl.rd_write     = 1'b1;
                    ctrl.jump         = 1'b1;
                    ctrl.src1_sel_pc  = 1'b1;
                    ctrl.src2_sel_imm = 1'b1;
                    ctrl.alu_op       = alu_base(F3_ADD, 1'b0);
                    ctrl.imm          = imm_j;
                end
                OPC_JALR: begin
                    legal             = (funct3 == F3_JALR);
                    ctrl.rd_write     = 1'b1;
                    ctrl.rs1_read     = 1'b1;
                    ctrl.jump         = 1'b1;
                    ctrl.src2_sel_imm = 1'b1;
                    ctrl.alu_op       = alu_base(F3_ADD, 1'b0);
                    ctrl.imm          = imm_i;
                end
                OPC_BRANCH: begin
                    legal         = (funct3 != 3'd2) && (funct3 != 3'd3);
                    ctrl.rs1_read = 1'b1;
                    ctrl.rs2_read = 1'b1;
                    ctrl.branch   = 1'b1;
                    ctrl.imm      = imm_b;
                    ctrl.unsign   = funct3[2] & funct3[1];
                    // Comparison flavour drives the ALU: equality via SUB, ordering via SLT/SLTU.
                    case (funct3)
                        F3_BEQ:  begin ctrl.branch_op[BRANCH_OP_EQ]  = 1'b1; ctrl.alu_op[ALU_OP_SUB]  = 1'b1; end
                        F3_BNE:  begin ctrl.branch_op[BRANCH_OP_NE]  = 1'b1; ctrl.alu_op[ALU_OP_SUB]  = 1'b1; end
                        F3_BLT:  begin ctrl.branch_op[BRANCH_OP_LT]  = 1'b1; ctrl.alu_op[ALU_OP_SLT]  = 1'b1; end
                        F3_BGE:  begin ctrl.branch_op[BRANCH_OP_GE]  = 1'b1; ctrl.alu_op[ALU_OP_SLT]  = 1'b1; end
                        F3_BLTU: begin ctrl.branch_op[BRANCH_OP_LTU] = 1'b1; ctrl.alu_op[ALU_OP_SLTU] = 1'b1; end
                        F3_BGEU: begin ctrl.branch_op[BRANCH_OP_GEU] = 1'b1; ctrl.alu_op[ALU_OP_SLTU] = 1'b1; end
                        default: ;
                    endcase
                end
                OPC_LOAD: begin
                    legal             = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW)
                                     || (funct3 == F3_LBU) || (funct3 == F3_LHU);
                    ctrl.rd_write     = 1'b1;
                    ctrl.rs1_read     = 1'b1;
                    ctrl.mem_read     = 1'b1;
                    ctrl.src2_sel_imm = 1'b1;
                    ctrl.alu_op       = alu_base(F3_ADD, 1'b0);
                    ctrl.imm          = imm_i;
                    ctrl.unsign       = funct3[2];
                    case (funct3[1:0])
                        2'd0:    ctrl.mem_op[MEM_OP_B] = 1'b1;
                        2'd1:    ctrl.mem_op[MEM_OP_H] = 1'b1;
                        2'd2:    ctrl.mem_op[MEM_OP_W] = 1'b1;
                        default: ;
                    endcase
                end
                OPC_STORE: begin
                    legal             = (funct3 <= F3_SW);
                    ctrl.rs1_read     = 1'b1;
                    ctrl.rs2_read     = 1'b1;
                    ctrl.mem_write    = 1'b1;
                    ctrl.src2_sel_imm = 1'b1;
                    ctrl.alu_op       = alu_base(F3_ADD, 1'b0);
                    ctrl.imm          = imm_s;
                    case (funct3[1:0])
                        2'd0:    ctrl.mem_op[MEM_OP_B] = 1'b1;
                        2'd1:    ctrl.mem_op[MEM_OP_H] = 1'b1;
                        2'd2:    ctrl.mem_op[MEM_OP_W] = 1'b1;
                        default: ;
                    endcase
                end
                OPC_ITYPE: begin
                    // Shift immediates reuse funct7; only SRAI may set bit 30.
                    if (funct3 == F3_SLL) begin
                        legal = (funct7 == F7_BASE);
                    end else if (funct3 == F3_SR) begin
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end else begin
                        legal = 1'b1;
                    end
                    ctrl.rd_write     = 1'b1;
                    ctrl.rs1_read     = 1'b1;
                    ctrl.src2_sel_imm = 1'b1;
                    ctrl.imm          = imm_i;
                    ctrl.unsign       = (funct3 == F3_SLTU);
                    ctrl.alu_op       = alu_base(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
                end
                OPC_RTYPE: begin
                    ctrl.rd_write = 1'b1;
                    ctrl.rs1_read = 1'b1;
                    ctrl.rs2_read = 1'b1;
                    ctrl.unsign   = (funct3 == F3_SLTU);
                    if (funct7 == F7_BASE) begin
                        legal       = 1'b1;
                        ctrl.alu_op = alu_base(funct3, 1'b0);
                    end else if (funct7 == F7_ALT) begin
                        legal       = (funct3 == F3_ADD) || (funct3 == F3_SR);
                        ctrl.alu_op = alu_base(funct3, 1'b1);
                    end else if ((funct7 == F7_MULDIV) && ENABLE_M) begin
                        legal          = 1'b1;
                        ctrl.is_muldiv = 1'b1;
                        ctrl.alu_op    = ALU_OP_W'(1) << (ALU_OP_MUL + 32'(funct3));
                    end
                end
                default: legal = 1'b0;
            endcase
        end

        if (!legal) begin
            ctrl.rd_write  = 1'b0;
            ctrl.rs1_read  = 1'b0;
            ctrl.rs2_read  = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.branch    = 1'b0;
            ctrl.jump      = 1'b0;
            ctrl.is_muldiv = 1'b0;
        end
        ctrl.illegal = ~legal;
    end

    assign ctrl_c = ctrl;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder feeding a 2-entry skid buffer with valid/ready,
// flush, and a saturating count of accepted illegal instructions.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          ENABLE_M  = 1'b0,
    parameter int unsigned ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ILEN-1:0]      in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [XLEN-1:0]      out_pc,
    output logic [ILEN-1:0]      out_instr,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    if (XLEN != XLEN_SUPPORTED) begin : g_bad_xlen
        $error("decode_stage: only XLEN=32 is supported");
    end

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   pc;
        logic [ILEN-1:0]   instr;
    } entry_t;

    logic [CTRL_W-1:0]    dec_ctrl_c;
    decode_ctrl_t         dec_view_c;
    entry_t               new_entry_c;
    logic                 accept_c;
    logic                 pop_c;

    occ_e                 count_q, count_d;
    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    decode_logic #(
        .ENABLE_M (ENABLE_M)
    ) u_decode_logic (
        .instr  (in_instr),
        .ctrl_c (dec_ctrl_c)
    );

    assign dec_view_c  = decode_ctrl_t'(dec_ctrl_c);
    assign new_entry_c = '{ctrl: dec_ctrl_c, pc: in_pc, instr: in_instr};
    assign accept_c    = in_valid & in_ready_q;
    assign pop_c       = out_valid_q & out_ready;

    // Occupancy and slot movement; head is always the entry presented to EX.
    always_comb begin
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        ill_cnt_d = ill_cnt_q;

        if (flush) begin
            count_d = OCC_EMPTY;
        end else begin
            case (count_q)
                OCC_EMPTY: begin
                    if (accept_c) begin
                        head_d  = new_entry_c;
                        count_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept_c && pop_c) begin
                        head_d = new_entry_c;
                    end else if (accept_c) begin
                        tail_d  = new_entry_c;
                        count_d = OCC_FULL;
                    end else if (pop_c) begin
                        count_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop_c) begin
                        head_d  = tail_q;
                        count_d = OCC_ONE;
                    end
                end
                default: count_d = OCC_EMPTY;
            endcase

            if (accept_c && dec_view_c.illegal && (ill_cnt_q != '1)) begin
                ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
            end
        end

        in_ready_d  = (count_d != OCC_FULL);
        out_valid_d = (count_d != OCC_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q     <= OCC_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ill_cnt_q   <= '0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = head_q.ctrl;
    assign out_pc    = head_q.pc;
    assign out_instr = head_q.instr;
    assign ill_cnt   = ill_cnt_q;

endmodule
